// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive paths.
//   uart_state_e    - frame state encoding, also exported on debug ports
//   UART_OVERSAMPLE - default baud_clk cycles per serial bit
//   UART_FRAME_BITS - default frame length (start + 8 data + stop)
//   UART_FC_W       - width of the frame bit index counter
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_FRAME_BITS = 10;
  localparam int unsigned UART_FC_W       = 4;

endpackage

// File: rtl/uart_tx_framer_if.sv
// uart_tx_framer_if: byte handshake between a producer and the UART transmitter.
//   tx_data    - byte to send, sampled on accept
//   tx_valid   - producer has data
//   tx_ready   - transmitter can accept
//   parity_odd - odd-parity select, present only with UART_TX_PARITY_EN
// Modports: master (producer side), slave (transmitter side).
interface uart_tx_framer_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = UART_FRAME_BITS - 2
) ();

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

`ifdef UART_TX_PARITY_EN
  logic                 parity_odd;

  modport master (output tx_data, output tx_valid, output parity_odd, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input parity_odd, output tx_ready);
`else
  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
`endif

endinterface

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: per-bit oversample counter for the UART transmitter.
//   baud_clk         - oversampling clock
//   rst              - asynchronous active-high reset
//   i_active         - frame in progress; counter held at 0 otherwise
//   o_boundary_c     - last oversample cycle of the current bit
//   o_pre_boundary_c - cycle before the bit boundary
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic baud_clk,
  input  logic rst,
  input  logic i_active,
  output logic o_boundary_c,
  output logic o_pre_boundary_c
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);

  logic [CNT_W-1:0] r_sample_cnt;

  assign o_boundary_c     = i_active && (r_sample_cnt == CNT_W'(OVERSAMPLE - 1));
  assign o_pre_boundary_c = i_active && (r_sample_cnt == CNT_W'(OVERSAMPLE - 2));

  // Counts 0..OVERSAMPLE-1 while active, wraps at each bit boundary.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      r_sample_cnt <= '0;
    end else if (!i_active || o_boundary_c) begin
      r_sample_cnt <= '0;
    end else begin
      r_sample_cnt <= r_sample_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: UART transmitter, one byte per handshake into a
// start / DATA_BITS data (LSB first) / [parity] / STOP_BITS stop frame.
//   baud_clk      - oversampling clock, all logic on rising edge
//   rst           - asynchronous active-high reset
//   bus           - slave side of uart_tx_framer_if (tx_data/tx_valid/tx_ready)
//   tx_serial     - serial line, idles high
//   tx_busy       - frame in progress
//   tx_done       - pulse in the final cycle of the last stop bit
//   current_state - uart_state_e encoding
//   frame_count   - bit index within the frame (0 = start bit)
// Optional: define UART_TX_PARITY_EN to insert a parity bit after the data.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_FRAME_BITS - 2,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 baud_clk,
  input  logic                 rst,
  uart_tx_framer_if.slave      bus,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [1:0]           current_state,
  output logic [UART_FC_W-1:0] frame_count
);

  localparam int unsigned FC_W = UART_FC_W;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif
  localparam logic [FC_W-1:0] DATA_LAST = FC_W'(DATA_BITS + PAR_BITS);
  localparam logic [FC_W-1:0] FC_LAST   = FC_W'(DATA_BITS + PAR_BITS + STOP_BITS);

  uart_state_e          r_state, w_state_n;
  logic [FC_W-1:0]      r_fc, w_fc_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic                 r_tx_serial, w_tx_serial_n;
  logic                 r_tx_ready, r_tx_busy, r_tx_done, w_tx_done_n;
  logic                 w_accept, w_boundary, w_pre_boundary;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity, w_parity_n;
`endif

  uart_tx_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
    .baud_clk         (baud_clk),
    .rst              (rst),
    .i_active         (r_state != IDLE),
    .o_boundary_c     (w_boundary),
    .o_pre_boundary_c (w_pre_boundary)
  );

  // r_tx_ready is high exactly when the state register holds IDLE.
  assign w_accept = bus.tx_valid && r_tx_ready;

  // Next state, frame index, shift register and next line level.
  always_comb begin
    w_state_n     = r_state;
    w_fc_n        = r_fc;
    w_shift_n     = r_shift;
    w_tx_serial_n = 1'b1;
`ifdef UART_TX_PARITY_EN
    w_parity_n    = r_parity;
`endif

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_n  = START;
          w_shift_n  = bus.tx_data;
`ifdef UART_TX_PARITY_EN
          w_parity_n = (^bus.tx_data) ^ bus.parity_odd;
`endif
        end
      end
      START: begin
        if (w_boundary) begin
          w_state_n = DATA;
          w_fc_n    = FC_W'(1);
        end
      end
      DATA: begin
        if (w_boundary) begin
          w_fc_n    = r_fc + FC_W'(1);
          w_shift_n = r_shift >> 1;
          if (r_fc == DATA_LAST) begin
            w_state_n = STOP;
          end
        end
      end
      STOP: begin
        if (w_boundary) begin
          if (r_fc == FC_LAST) begin
            w_state_n = IDLE;
            w_fc_n    = '0;
          end else begin
            w_fc_n = r_fc + FC_W'(1);
          end
        end
      end
      default: w_state_n = IDLE;
    endcase

    // Line level for the cycle after this edge.
    case (w_state_n)
      START:   w_tx_serial_n = 1'b0;
`ifdef UART_TX_PARITY_EN
      DATA:    w_tx_serial_n = (w_fc_n == FC_W'(DATA_BITS + 1)) ? w_parity_n : w_shift_n[0];
`else
      DATA:    w_tx_serial_n = w_shift_n[0];
`endif
      default: w_tx_serial_n = 1'b1;
    endcase
  end

  // Registered done lands in the boundary cycle of the last stop bit.
  assign w_tx_done_n = (r_state == STOP) && (r_fc == FC_LAST) && w_pre_boundary;

  // State and output registers.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_fc        <= '0;
      r_shift     <= '0;
      r_tx_serial <= 1'b1;
      r_tx_ready  <= 1'b1;
      r_tx_busy   <= 1'b0;
      r_tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_fc        <= w_fc_n;
      r_shift     <= w_shift_n;
      r_tx_serial <= w_tx_serial_n;
      r_tx_ready  <= (w_state_n == IDLE);
      r_tx_busy   <= (w_state_n != IDLE);
      r_tx_done   <= w_tx_done_n;
`ifdef UART_TX_PARITY_EN
      r_parity    <= w_parity_n;
`endif
    end
  end

  assign bus.tx_ready  = r_tx_ready;
  assign tx_serial     = r_tx_serial;
  assign tx_busy       = r_tx_busy;
  assign tx_done       = r_tx_done;
  assign current_state = r_state;
  assign frame_count   = r_fc;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: self-checking bench for uart_tx_framer.
// Two instances: defaults, and OVERSAMPLE=8 / STOP_BITS=2.
// Expected line behaviour comes from a frame model built from bit positions.
module tb_uart_tx_framer;
  import uart_pkg::*;

  localparam int unsigned DB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  // Observation vector: {serial, frame_count[3:0], state[1:0], done, ready, busy}
  localparam logic [9:0] IDLE_VEC = {1'b1, 4'd0, 2'b00, 1'b0, 1'b1, 1'b0};

  logic baud_clk = 1'b0;
  always #5 baud_clk = ~baud_clk;

  logic       rst, rst2;
  logic       ser1, busy1, done1, ser2, busy2, done2;
  logic [1:0] st1, st2;
  logic [3:0] fc1, fc2;
  logic       sel;
  logic       cur_podd;
  logic [9:0] obs;
  int         total = 0;
  int         bad   = 0;

  uart_tx_framer_if #(.DATA_BITS(DB)) bus1 ();
  uart_tx_framer_if #(.DATA_BITS(DB)) bus2 ();

`ifdef UART_TX_PARITY_EN
  assign bus1.parity_odd = cur_podd;
  assign bus2.parity_odd = cur_podd;
`endif

  uart_tx_framer #(.DATA_BITS(DB), .OVERSAMPLE(16), .STOP_BITS(1)) dut (
    .baud_clk(baud_clk), .rst(rst), .bus(bus1), .tx_serial(ser1), .tx_busy(busy1),
    .tx_done(done1), .current_state(st1), .frame_count(fc1));

  uart_tx_framer #(.DATA_BITS(DB), .OVERSAMPLE(8), .STOP_BITS(2)) dut2 (
    .baud_clk(baud_clk), .rst(rst2), .bus(bus2), .tx_serial(ser2), .tx_busy(busy2),
    .tx_done(done2), .current_state(st2), .frame_count(fc2));

  assign obs = sel ? {ser2, fc2, st2, done2, bus2.tx_ready, busy2}
                   : {ser1, fc1, st1, done1, bus1.tx_ready, busy1};

  function automatic int frame_len(int os, int sb);
    return os * (1 + DB + PAR + sb);
  endfunction

  // Expected observation idx cycles after the accept edge.
  function automatic logic [9:0] exp_vec(logic [7:0] b, logic podd, int idx, int os, int sb);
    int         len;
    int         bitn;
    logic       s;
    logic [1:0] st;
    len = frame_len(os, sb);
    if (idx >= len) return IDLE_VEC;
    bitn = idx / os;
    if (bitn == 0) begin
      s = 1'b0; st = 2'b01;
    end else if (bitn <= DB) begin
      s = b[bitn-1]; st = 2'b10;
    end else if (PAR == 1 && bitn == DB + 1) begin
      s = (^b) ^ podd; st = 2'b10;
    end else begin
      s = 1'b1; st = 2'b11;
    end
    return {s, 4'(bitn), st, 1'(idx == len - 1), 1'b0, 1'b1};
  endfunction

  task automatic drive(logic v, logic [7:0] d);
    if (sel) begin
      bus2.tx_valid = v; bus2.tx_data = d;
    end else begin
      bus1.tx_valid = v; bus1.tx_data = d;
    end
  endtask

  // Accept one byte and compare every cycle of the frame plus the idle cycle after.
  task automatic check_frame(string name, logic [7:0] b, int os, int sb);
    int         len;
    logic [9:0] e;
    len = frame_len(os, sb);
    @(negedge baud_clk);
    total++;
    if (obs[1] !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_before_accept got=%b exp=1", name, obs[1]);
    end
    drive(1'b1, b);
    @(posedge baud_clk);
    @(negedge baud_clk);
    drive(1'b0, 8'($urandom));
    for (int idx = 0; idx <= len; idx++) begin
      e = exp_vec(b, cur_podd, idx, os, sb);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s idx=%0d got=%b exp=%b", name, idx, obs, e);
      end
      if (idx < len) @(negedge baud_clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1;
    sel = 1'b0; drive(1'b0, 8'h00);
    sel = 1'b1; drive(1'b0, 8'h00);
    repeat (3) @(negedge baud_clk);
    for (int k = 0; k < 2; k++) begin
      sel = 1'(k);
      #1;
      total++;
      if (obs !== IDLE_VEC) begin
        bad++;
        $display("FAIL reset_state dut%0d got=%b exp=%b", k, obs, IDLE_VEC);
      end
    end
    @(negedge baud_clk);
    rst = 1'b0; rst2 = 1'b0;
    sel = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge baud_clk);
      total++;
      if (obs !== IDLE_VEC) begin
        bad++;
        $display("FAIL idle cycle=%0d got=%b exp=%b", c, obs, IDLE_VEC);
      end
    end
  endtask

  task automatic test_back_to_back();
    int         len;
    int         period;
    int         dones;
    int         second_start;
    logic [7:0] b;
    logic [9:0] e;
    sel = 1'b0;
    len = frame_len(16, 1);
    period = len + 1;
    dones = 0;
    second_start = -1;
    @(negedge baud_clk);
    drive(1'b1, 8'h00);
    @(posedge baud_clk);
    @(negedge baud_clk);
    drive(1'b1, 8'hFF);
    for (int i = 0; i < 2 * period; i++) begin
      b = (i < period) ? 8'h00 : 8'hFF;
      e = exp_vec(b, cur_podd, i % period, 16, 1);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL b2b i=%0d got=%b exp=%b", i, obs, e);
      end
      if (obs[2] === 1'b1) dones++;
      if (second_start < 0 && i >= len && obs[4:3] === 2'b01) second_start = i;
      if (i == period) drive(1'b0, 8'($urandom));
      if (i < 2 * period - 1) @(negedge baud_clk);
    end
    total++;
    if (dones != 2) begin
      bad++;
      $display("FAIL b2b_done_count got=%0d exp=2", dones);
    end
    total++;
    if (second_start != period) begin
      bad++;
      $display("FAIL b2b_period got=%0d exp=%0d", second_start, period);
    end
  endtask

  task automatic test_reset_midframe();
    sel = 1'b0;
    @(negedge baud_clk);
    drive(1'b1, 8'h00);
    @(posedge baud_clk);
    @(negedge baud_clk);
    drive(1'b0, 8'h00);
    repeat (70) @(negedge baud_clk);
    total++;
    if (obs !== exp_vec(8'h00, cur_podd, 70, 16, 1)) begin
      bad++;
      $display("FAIL pre_reset got=%b exp=%b", obs, exp_vec(8'h00, cur_podd, 70, 16, 1));
    end
    rst = 1'b1;
    #1;
    total++;
    if (obs !== IDLE_VEC) begin
      bad++;
      $display("FAIL reset_immediate got=%b exp=%b", obs, IDLE_VEC);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge baud_clk);
      total++;
      if (obs !== IDLE_VEC) begin
        bad++;
        $display("FAIL reset_hold cycle=%0d got=%b exp=%b", c, obs, IDLE_VEC);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge baud_clk);
      total++;
      if (obs !== IDLE_VEC) begin
        bad++;
        $display("FAIL post_reset_idle cycle=%0d got=%b exp=%b", c, obs, IDLE_VEC);
      end
    end
    check_frame("after_reset_3c", 8'h3C, 16, 1);
  endtask

  task automatic test_random();
    logic [7:0] b;
    sel = 1'b0;
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      cur_podd = 1'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge baud_clk);
      check_frame("random", b, 16, 1);
    end
    cur_podd = 1'b0;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    sel = 1'b0;
    cur_podd = 1'b0;
    check_frame("parity_even_07", 8'h07, 16, 1);
    cur_podd = 1'b1;
    check_frame("parity_odd_07", 8'h07, 16, 1);
    cur_podd = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    cur_podd = 1'b0;
    test_reset();
    sel = 1'b0;
    check_frame("a5", 8'hA5, 16, 1);
    test_back_to_back();
    test_reset_midframe();
    sel = 1'b1;
    check_frame("stop2_os8_81", 8'h81, 8, 2);
    sel = 1'b0;
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- UART transmitter: serialises one byte per handshake into a 1-start / DATA_BITS-data (LSB first) / STOP_BITS-stop frame on tx_serial.
- Clocked by the 16x oversampling baud_clk shared with the receive path; each bit is held for OVERSAMPLE baud_clk cycles.
- Exports state and frame bit index with the same encoding as the receive-side frame counter, so debug and monitoring logic can treat both directions alike.

Parameters:
- DATA_BITS, 8, payload bits per frame; legal 5..8.
- OVERSAMPLE, 16, baud_clk cycles per bit; legal 4..16.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.

Ports:
- baud_clk  in  1  oversampling clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- tx_data  in  DATA_BITS  byte to send; sampled only on accept.
- tx_valid  in  1  producer has data.
- tx_ready  out  1  block can accept; high only in IDLE.
- tx_serial  out  1  serial line; idles high.
- tx_busy  out  1  high in START, DATA and STOP.
- tx_done  out  1  one-cycle pulse in the final cycle of the last stop bit.
- current_state  out  2  00 IDLE, 01 START, 10 DATA, 11 STOP.
- frame_count  out  4  bit index within the frame: 0 = start, 1..DATA_BITS = data, then stop bit(s).

Behaviour:
- Reset (asynchronous, immediate):
  - state IDLE; sample_cnt, frame_count, shift register cleared.
  - tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0.
  - Reset mid-frame truncates the frame; the line goes high immediately and no tx_done is emitted.
- Accept: tx_valid && tx_ready at an edge in IDLE.
  - tx_data is latched into the shift register and state goes to START.
  - tx_serial goes 0 at that same edge, giving 1 cycle latency from accept to start bit.
  - tx_valid without tx_ready is ignored; the producer must hold tx_valid.
- sample_cnt:
  - counts 0..OVERSAMPLE-1 in START, DATA and STOP; is 0 in IDLE.
  - A bit boundary is the cycle with sample_cnt==OVERSAMPLE-1; sample_cnt wraps to 0 there.
- START: tx_serial=0 for OVERSAMPLE cycles. At the boundary, go to DATA and set frame_count=1.
- DATA:
  - tx_serial = shift[0].
  - At each boundary, shift right by one and increment frame_count.
  - After frame_count==DATA_BITS completes, go to STOP.
- STOP:
  - tx_serial=1 for OVERSAMPLE*STOP_BITS cycles; frame_count increments per stop bit.
  - On the final boundary: tx_done=1 for that cycle, then go to IDLE and clear frame_count to 0.
- IDLE lasts at least 1 cycle between frames. Back-to-back period = OVERSAMPLE*(2+DATA_BITS+STOP_BITS-1)+1 cycles, i.e. 161 at defaults.
- tx_data changes after accept have no effect on the frame in flight.
- frame_count is 4 bits and never exceeds DATA_BITS+STOP_BITS+1 (max 11).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- With the macro defined:
  - Adds input parity_odd (1 bit, sampled at accept).
  - Inserts a parity bit after the last data bit, held OVERSAMPLE cycles, with frame_count = DATA_BITS+1; state stays DATA for that bit.
  - Parity bit value is XOR of the data bits, XOR parity_odd.
  - Frame lengthens by OVERSAMPLE cycles.
- Without the macro: no parity_odd port, no parity logic; frame exactly as above.

Decomposition:
- Shared package uart_pkg:
  - enum uart_state_e (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11), shared with the receive path.
  - Constants UART_OVERSAMPLE=16 and UART_FRAME_BITS=10.
- One sub-module: uart_tx_bit_timer.
  - Holds the sample_cnt counter and the bit-boundary strobe.
  - Uses the same structure as the receive-side stop/sample counter.
- FSM and shift register remain in uart_tx_framer.

Test Plan:
- Reset then idle 50 cycles -> tx_serial=1, tx_ready=1, tx_busy=0, current_state=00 throughout.
- Send 8'hA5 at defaults -> line shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit 16 cycles; tx_done pulses exactly 160 cycles after accept; frame_count steps 0..9.
- Two bytes 8'h00 and 8'hFF with tx_valid held high -> second start bit begins 161 cycles after the first; tx_ready low during each frame; exactly 2 tx_done pulses.
- Assert rst at cycle 70 of a frame (within data bit 3) -> tx_serial=1 in the same cycle, state IDLE, no tx_done; a new byte 8'h3C sent afterwards is correct.
- STOP_BITS=2, OVERSAMPLE=8, byte 8'h81 -> stop high for 16 cycles; tx_done 88 cycles after accept.
- With UART_TX_PARITY_EN, byte 8'h07 -> parity_odd=0 gives parity bit 1; parity_odd=1 gives 0; tx_done at 176 cycles after accept.
